// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared types and sizing helpers for the CNN front-end im2col.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int out_dim(input int img, input int k, input int stride);
        return (img - k) / stride + 1;
    endfunction

    // Index width for a counter ranging over 0..n-1, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int window_index(input int m, input int n, input int c,
                                        input int k, input int ch);
        return (m * k + n) * ch + c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/im2col_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : im2col_stream_if
// Description : Pixel-in / window-out handshake bundle for im2col_stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface im2col_stream_if #(
    parameter int DATA_W = 8,
    parameter int CH     = 1,
    parameter int K      = 3,
    parameter int ROW_W  = 5,
    parameter int COL_W  = 5
);
    logic                       in_valid;
    logic                       in_ready;
    logic [CH*DATA_W-1:0]       in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [K*K*CH*DATA_W-1:0]   out_data;
    logic [ROW_W-1:0]           out_row;
    logic [COL_W-1:0]           out_col;
    logic                       out_last;
    logic                       frame_done;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_row, out_col, out_last, frame_done
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_row, out_col, out_last, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/im2col_stream_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer
// Description : ROWS cascaded row delays of DEPTH entries, addressed by column.
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 28,
    parameter int ROWS  = 2,
    parameter int AW    = 5
) (
    input  wire logic                  clk,
    input  wire logic                  shift_en_i,
    input  wire logic [AW-1:0]         addr_i,
    input  wire logic [WIDTH-1:0]      din_i,
    output logic      [ROWS*WIDTH-1:0] taps_o
);

    // Read-before-write at the current column: each row hands its old entry
    // to the next row down, so tap j is the pixel j+1 rows above.
    for (genvar j = 0; j < ROWS; j++) begin : g_row
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [WIDTH-1:0] row_in;

        if (j == 0) begin : g_head
            assign row_in = din_i;
        end else begin : g_tail
            assign row_in = taps_o[(j-1)*WIDTH +: WIDTH];
        end

        assign taps_o[j*WIDTH +: WIDTH] = mem_q[addr_i];

        always_ff @(posedge clk) begin
            if (shift_en_i) begin
                mem_q[addr_i] <= row_in;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/im2col_stream.sv
`default_nettype none
// ============================================================================
// Module      : im2col_stream
// Description : Streaming im2col: raster pixels in, flattened KxKxCH windows out.
// Revision    : 1.0 - initial release
// ============================================================================
module im2col_stream
    import cnn_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3,
    parameter int STRIDE = 1,
    parameter int CH     = 1
) (
    input  wire logic           clk,
    input  wire logic           reset,
    im2col_stream_if.slave      bus
);

    localparam int PXW   = CH * DATA_W;
    localparam int WINW  = K * K * PXW;
    localparam int OUT_W = out_dim(IMG_W, K, STRIDE);
    localparam int OUT_H = out_dim(IMG_H, K, STRIDE);
    localparam int CW    = idx_w(IMG_W);
    localparam int RW    = idx_w(IMG_H);
    localparam int OCW   = idx_w(OUT_W);
    localparam int ORW   = idx_w(OUT_H);
    localparam int PHW   = idx_w(STRIDE);

    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [PHW-1:0]  cph_q, cph_d, rph_q, rph_d;
    logic [OCW-1:0]  ocol_q, ocol_d;
    logic [ORW-1:0]  orow_q, orow_d;
    state_e          state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [WINW-1:0] out_data_q, out_data_d;
    logic [ORW-1:0]  out_row_q, out_row_d;
    logic [OCW-1:0]  out_col_q, out_col_d;
    logic            out_last_q, out_last_d;
    logic            frame_done_q, frame_done_d;
    logic [PXW-1:0]  win_q [K][K];
    logic [PXW-1:0]  win_d [K][K];
    logic [PXW-1:0]  colnew [K];
    logic [(K-1)*PXW-1:0] lb_taps;

    logic accept, eol, eof, emit, ready;

    assign ready  = !out_valid_q || bus.out_ready;
    assign accept = bus.in_valid && ready;
    assign eol    = (col_q == CW'(IMG_W - 1));
    assign eof    = eol && (row_q == RW'(IMG_H - 1));
    assign emit   = accept && (state_q == RUN) && (col_q >= CW'(K - 1)) &&
                    (cph_q == '0) && (rph_q == '0);

    line_buffer #(
        .WIDTH (PXW),
        .DEPTH (IMG_W),
        .ROWS  (K - 1),
        .AW    (CW)
    ) u_line_buffer (
        .clk        (clk),
        .shift_en_i (accept),
        .addr_i     (col_q),
        .din_i      (bus.in_data),
        .taps_o     (lb_taps)
    );

    // Oldest buffered row is the top of the window column.
    always_comb begin
        for (int m = 0; m < K; m++) begin
            colnew[m] = bus.in_data;
        end
        for (int m = 0; m < K - 1; m++) begin
            colnew[m] = lb_taps[(K-2-m)*PXW +: PXW];
        end
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        cph_d        = cph_q;
        rph_d        = rph_q;
        state_d      = state_q;
        ocol_d       = ocol_q;
        orow_d       = orow_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        out_last_d   = out_last_q;
        frame_done_d = 1'b0;
        for (int m = 0; m < K; m++) begin
            for (int n = 0; n < K; n++) begin
                win_d[m][n] = win_q[m][n];
            end
        end

        if (accept) begin
            for (int m = 0; m < K; m++) begin
                for (int n = 0; n < K - 1; n++) begin
                    win_d[m][n] = win_q[m][n+1];
                end
                win_d[m][K-1] = colnew[m];
            end

            // Phases are zero on the first window-capable column/row.
            if (col_q == CW'(K - 2) || cph_q == PHW'(STRIDE - 1)) begin
                cph_d = '0;
            end else begin
                cph_d = cph_q + 1'b1;
            end

            if (eol) begin
                col_d = '0;
                if (row_q == RW'(K - 2) || rph_q == PHW'(STRIDE - 1)) begin
                    rph_d = '0;
                end else begin
                    rph_d = rph_q + 1'b1;
                end
                if (eof) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end

            case (state_q)
                FILL:    if (eol && row_q == RW'(K - 2)) state_d = RUN;
                RUN:     if (eof) state_d = FILL;
                default: state_d = FILL;
            endcase
        end

        if (emit) begin
            out_valid_d = 1'b1;
            out_row_d   = orow_q;
            out_col_d   = ocol_q;
            out_last_d  = (ocol_q == OCW'(OUT_W - 1)) && (orow_q == ORW'(OUT_H - 1));
            for (int m = 0; m < K; m++) begin
                for (int n = 0; n < K; n++) begin
                    for (int c = 0; c < CH; c++) begin
                        out_data_d[window_index(m, n, c, K, CH)*DATA_W +: DATA_W] =
                            win_d[m][n][c*DATA_W +: DATA_W];
                    end
                end
            end
            if (ocol_q == OCW'(OUT_W - 1)) begin
                ocol_d = '0;
                orow_d = (orow_q == ORW'(OUT_H - 1)) ? '0 : orow_q + 1'b1;
            end else begin
                ocol_d = ocol_q + 1'b1;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            cph_q        <= '0;
            rph_q        <= '0;
            state_q      <= FILL;
            ocol_q       <= '0;
            orow_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            cph_q        <= cph_d;
            rph_q        <= rph_d;
            state_q      <= state_d;
            ocol_q       <= ocol_d;
            orow_q       <= orow_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Window contents are fully refilled along each row before any emit.
    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_row    = out_row_q;
    assign bus.out_col    = out_col_q;
    assign bus.out_last   = out_last_q;
    assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_im2col_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_im2col_stream
// Description : Self-checking bench for im2col_stream against a window model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_im2col_stream;

    typedef struct packed {
        logic [399:0] data;
        logic [7:0]   row;
        logic [7:0]   col;
        logic         last;
    } win_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    im2col_stream_if #(.DATA_W(8), .CH(1), .K(3), .ROW_W(5), .COL_W(5)) ifa ();
    im2col_stream_if #(.DATA_W(8), .CH(1), .K(3), .ROW_W(4), .COL_W(4)) ifb ();
    im2col_stream_if #(.DATA_W(8), .CH(2), .K(5), .ROW_W(1), .COL_W(2)) ifc ();

    im2col_stream #(.DATA_W(8), .IMG_W(28), .IMG_H(28), .K(3), .STRIDE(1), .CH(1))
        u_a (.clk(clk), .reset(reset), .bus(ifa));
    im2col_stream #(.DATA_W(8), .IMG_W(28), .IMG_H(28), .K(3), .STRIDE(2), .CH(1))
        u_b (.clk(clk), .reset(reset), .bus(ifb));
    im2col_stream #(.DATA_W(8), .IMG_W(8), .IMG_H(6), .K(5), .STRIDE(1), .CH(2))
        u_c (.clk(clk), .reset(reset), .bus(ifc));

    logic [15:0] img_q[$];
    logic [15:0] inq[$];
    win_t        exp_q[$];
    win_t        obs_q[$];
    int          checks = 0;
    int          failures = 0;
    int          sel = 0;
    int          rmode = 0;
    bit          gaps = 1'b0;
    int          stall_cnt = 0;
    int          stall_seen = 0;
    int          stall_bad = 0;
    bit          held = 1'b0;
    win_t        snap;
    int          acc = 0;
    int          fd = 0;

    task automatic chk(input string tag, input logic [511:0] o, input logic [511:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Pixel beat: channel 0 in [7:0]; channel 1 = channel 0 + 128 in [15:8].
    task automatic mk_frame(input int w, input int h, input int ch, input bit rnd);
        img_q.delete();
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                logic [7:0]  p0;
                logic [15:0] px;
                p0 = rnd ? 8'($urandom_range(0, 255)) : 8'((r * w + c) % 256);
                px = (ch == 2) ? {p0 + 8'd128, p0} : {8'd0, p0};
                img_q.push_back(px);
                inq.push_back(px);
            end
        end
    endtask

    task automatic gen_exp(input int w, input int h, input int k, input int s, input int ch);
        int ow, oh;
        ow = (w - k) / s + 1;
        oh = (h - k) / s + 1;
        for (int orow = 0; orow < oh; orow++) begin
            for (int ocol = 0; ocol < ow; ocol++) begin
                win_t e;
                e = '0;
                for (int m = 0; m < k; m++)
                    for (int n = 0; n < k; n++)
                        for (int c = 0; c < ch; c++)
                            e.data[((m*k+n)*ch+c)*8 +: 8] =
                                img_q[(orow*s+m)*w + ocol*s + n][c*8 +: 8];
                e.row  = 8'(orow);
                e.col  = 8'(ocol);
                e.last = (orow == oh - 1) && (ocol == ow - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    function automatic bit act_valid();
        case (sel)
            0:       return ifa.out_valid;
            1:       return ifb.out_valid;
            default: return ifc.out_valid;
        endcase
    endfunction

    task automatic tick();
        logic v, r, iv, ir, fdn, rdy, ivl;
        logic [15:0] d;
        win_t w;
        @(negedge clk);
        w = '0;
        case (sel)
            0: begin
                v = ifa.out_valid; r = ifa.out_ready; iv = ifa.in_valid; ir = ifa.in_ready;
                fdn = ifa.frame_done; w.data[71:0] = ifa.out_data;
                w.row = 8'(ifa.out_row); w.col = 8'(ifa.out_col); w.last = ifa.out_last;
            end
            1: begin
                v = ifb.out_valid; r = ifb.out_ready; iv = ifb.in_valid; ir = ifb.in_ready;
                fdn = ifb.frame_done; w.data[71:0] = ifb.out_data;
                w.row = 8'(ifb.out_row); w.col = 8'(ifb.out_col); w.last = ifb.out_last;
            end
            default: begin
                v = ifc.out_valid; r = ifc.out_ready; iv = ifc.in_valid; ir = ifc.in_ready;
                fdn = ifc.frame_done; w.data = ifc.out_data;
                w.row = 8'(ifc.out_row); w.col = 8'(ifc.out_col); w.last = ifc.out_last;
            end
        endcase
        if (!reset) begin
            if (iv && ir) begin
                void'(inq.pop_front());
                acc++;
            end
            if (v && r) obs_q.push_back(w);
            if (fdn) fd++;
            if (held && w != snap) stall_bad++;
            if (v && !r) begin
                stall_seen++;
                if (ir) stall_bad++;
            end
            held = v && !r;
            snap = w;
        end else begin
            held = 1'b0;
        end

        @(posedge clk);
        #1;
        rdy = 1'b1;
        if (rmode == 1) rdy = 1'($urandom_range(0, 1));
        if (rmode == 2) begin
            rdy = !(obs_q.size() >= 300 && stall_cnt < 5);
            if (!rdy) stall_cnt++;
        end
        ivl = (inq.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
        d   = (inq.size() > 0) ? inq[0] : 16'd0;
        ifa.in_valid = 1'b0; ifa.out_ready = 1'b1; ifa.in_data = '0;
        ifb.in_valid = 1'b0; ifb.out_ready = 1'b1; ifb.in_data = '0;
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b1; ifc.in_data = '0;
        case (sel)
            0:       begin ifa.in_valid = ivl; ifa.out_ready = rdy; ifa.in_data = d[7:0]; end
            1:       begin ifb.in_valid = ivl; ifb.out_ready = rdy; ifb.in_data = d[7:0]; end
            default: begin ifc.in_valid = ivl; ifc.out_ready = rdy; ifc.in_data = d; end
        endcase
    endtask

    task automatic run_frame(input string tag);
        int n;
        n = 0;
        while ((inq.size() > 0 || act_valid()) && n < 20000) begin
            tick();
            n++;
        end
        chk({tag, " completes"}, n < 20000, 1);
        repeat (3) tick();
    endtask

    task automatic cmp(input string tag);
        int bad, n;
        bad = 0;
        chk({tag, " count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n && bad < 3; i++) begin
            int f0;
            f0 = failures;
            chk($sformatf("%s win%0d", tag, i), obs_q[i], exp_q[i]);
            if (failures > f0) bad++;
        end
    endtask

    task automatic start(input int s, input int rm, input bit g);
        sel = s; rmode = rm; gaps = g;
        stall_cnt = 0; stall_seen = 0; stall_bad = 0;
        obs_q.delete(); exp_q.delete(); inq.delete();
        fd = 0; acc = 0;
    endtask

    initial begin
        logic [511:0] fw;
        int           fwv[9];
        int           n;
        fwv = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
        ifa.in_valid = 1'b0; ifa.out_ready = 1'b1; ifa.in_data = '0;
        ifb.in_valid = 1'b0; ifb.out_ready = 1'b1; ifb.in_data = '0;
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b1; ifc.in_data = '0;
        reset = 1'b1;
        repeat (3) tick();

        chk("rst out_valid", ifa.out_valid, 0);
        chk("rst out_data", ifa.out_data, 0);
        chk("rst out_row", ifa.out_row, 0);
        chk("rst out_col", ifa.out_col, 0);
        chk("rst out_last", ifa.out_last, 0);
        chk("rst frame_done", ifa.frame_done, 0);
        chk("rst in_ready", ifa.in_ready, 1);
        reset = 1'b0;

        // Ramp frame, free-running consumer.
        start(0, 0, 1'b0);
        mk_frame(28, 28, 1, 1'b0);
        gen_exp(28, 28, 3, 1, 1);
        run_frame("ramp");
        cmp("ramp");
        fw = '0;
        for (int i = 0; i < 9; i++) fw[i*8 +: 8] = 8'(fwv[i]);
        if (obs_q.size() > 0) chk("first window", obs_q[0].data, fw);
        if (obs_q.size() > 675)
            chk("last window pos", {obs_q[675].row, obs_q[675].col, obs_q[675].last},
                {8'd25, 8'd25, 1'b1});
        chk("ramp frame_done", fd, 1);

        // Five-cycle consumer stall mid-frame.
        start(0, 2, 1'b0);
        mk_frame(28, 28, 1, 1'b0);
        gen_exp(28, 28, 3, 1, 1);
        run_frame("stall");
        cmp("stall");
        chk("stall hold/in_ready violations", stall_bad, 0);
        chk("stall observed", stall_seen > 0, 1);

        // Random pixels, random consumer and producer gaps.
        start(0, 1, 1'b1);
        mk_frame(28, 28, 1, 1'b1);
        gen_exp(28, 28, 3, 1, 1);
        run_frame("random");
        cmp("random");
        chk("random hold violations", stall_bad, 0);
        chk("random frame_done", fd, 1);

        // Reset after 100 accepted beats, then a clean frame.
        start(0, 0, 1'b0);
        mk_frame(28, 28, 1, 1'b0);
        n = 0;
        while (acc < 100 && n < 1000) begin
            tick();
            n++;
        end
        chk("pre-reset beats", acc >= 100, 1);
        reset = 1'b1;
        tick();
        inq.delete(); obs_q.delete(); fd = 0;
        tick();
        reset = 1'b0;
        mk_frame(28, 28, 1, 1'b0);
        gen_exp(28, 28, 3, 1, 1);
        run_frame("after reset");
        cmp("after reset");
        chk("after reset frame_done", fd, 1);

        // Two random frames back to back, input never idle.
        start(0, 0, 1'b0);
        mk_frame(28, 28, 1, 1'b1);
        gen_exp(28, 28, 3, 1, 1);
        mk_frame(28, 28, 1, 1'b1);
        gen_exp(28, 28, 3, 1, 1);
        run_frame("b2b");
        cmp("b2b");
        chk("b2b frame_done", fd, 2);

        // Stride 2.
        start(1, 0, 1'b0);
        mk_frame(28, 28, 1, 1'b0);
        gen_exp(28, 28, 3, 2, 1);
        run_frame("stride2");
        cmp("stride2");
        if (obs_q.size() > 1) chk("stride2 second elem0", obs_q[1].data[7:0], 8'd2);
        if (obs_q.size() > 168)
            chk("stride2 last", {obs_q[168].data[7:0], obs_q[168].row, obs_q[168].col,
                obs_q[168].last}, {8'd184, 8'd12, 8'd12, 1'b1});
        chk("stride2 frame_done", fd, 1);

        // Two channels, K=5, 8x6 image; last window top-left (1,3).
        start(2, 1, 1'b1);
        mk_frame(8, 6, 2, 1'b0);
        gen_exp(8, 6, 5, 1, 2);
        run_frame("ch2");
        cmp("ch2");
        if (obs_q.size() > 7)
            chk("ch2 elem(4,4)", obs_q[7].data[399:384], {8'd175, 8'd47});
        chk("ch2 frame_done", fd, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
